// File: rtl/mem_stage_lsu.sv
// Memory stage: byte-addressable data RAM with lane-masked stores, extended loads,
// misalignment detection and the M/W pipeline register.
module mem_stage_lsu #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWriteM,
    input  logic [1:0]            ResultSrcM,
    input  logic                  MemWriteM,
    input  logic                  MemReadM,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic [4:0]            RdM,
    input  logic [DATA_WIDTH-1:0] PCPlus4M,
    input  logic [2:0]            LS_modeM,
    output logic                  RegWriteW,
    output logic [1:0]            ResultSrcW,
    output logic [DATA_WIDTH-1:0] ALUResultW,
    output logic [DATA_WIDTH-1:0] ReadDataW,
    output logic [4:0]            RdW,
    output logic [DATA_WIDTH-1:0] PCPlus4W,
    output logic                  MisalignW
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    localparam logic [2:0] ModeB  = 3'b000;
    localparam logic [2:0] ModeH  = 3'b001;
    localparam logic [2:0] ModeW  = 3'b010;
    localparam logic [2:0] ModeBu = 3'b100;
    localparam logic [2:0] ModeHu = 3'b101;

    logic [DATA_WIDTH-1:0] mem_q [Depth];

    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            off;
    logic                  is_b, is_h, is_w, is_undef;
    logic                  mis;
    logic [3:0]            byte_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  unused_addr_hi;

    // Upper address bits are intentionally dropped: accesses alias modulo RAM size.
    assign unused_addr_hi = ^ALUResultM[DATA_WIDTH-1:ADDR_WIDTH+2];

    assign word_idx = ALUResultM[ADDR_WIDTH+1:2];
    assign off      = ALUResultM[1:0];

    always_comb begin
        is_b     = (LS_modeM == ModeB) || (LS_modeM == ModeBu);
        is_h     = (LS_modeM == ModeH) || (LS_modeM == ModeHu);
        is_w     = (LS_modeM == ModeW);
        is_undef = !(is_b || is_h || is_w);
        mis      = (MemReadM || MemWriteM) &&
                   ((is_h && off[0]) || (is_w && (off != 2'b00)) || is_undef);
    end

    always_comb begin
        byte_en = 4'b0000;
        wr_data = WriteDataM;
        if (MemWriteM && !mis && !rst) begin
            if (is_b) begin
                byte_en = 4'b0001 << off;
                wr_data = {4{WriteDataM[7:0]}};
            end else if (is_h) begin
                byte_en = off[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{WriteDataM[15:0]}};
            end else begin
                byte_en = 4'b1111;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                mem_q[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Asynchronous read sees the pre-edge word, so a same-cycle store is not visible.
    assign rd_word = mem_q[word_idx];

    always_comb begin
        rd_byte   = rd_word[8*off +: 8];
        rd_half   = off[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = '0;
        if (MemReadM && !mis) begin
            unique case (LS_modeM)
                ModeB:   load_data = {{24{rd_byte[7]}}, rd_byte};
                ModeBu:  load_data = {24'b0, rd_byte};
                ModeH:   load_data = {{16{rd_half[15]}}, rd_half};
                ModeHu:  load_data = {16'b0, rd_half};
                ModeW:   load_data = rd_word;
                default: load_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= '0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            RdW        <= '0;
            PCPlus4W   <= '0;
            MisalignW  <= 1'b0;
        end else begin
            RegWriteW  <= RegWriteM;
            ResultSrcW <= ResultSrcM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= load_data;
            RdW        <= RdM;
            PCPlus4W   <= PCPlus4M;
            MisalignW  <= mis;
        end
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory stage of the 5-stage RISC-V pipeline. Sits directly downstream of the execute/memory pipeline register and consumes its M-stage outputs.
- Contains the byte-addressable data RAM. Generates byte-lane store writes and extracts and sign/zero-extends load data.
- Flags misaligned accesses.
- Registers everything needed for writeback into the memory/writeback boundary, so the W-stage signals come out of this block.

Parameters:
- DATA_WIDTH, 32, datapath width; fixed at 32 for RV32.
- ADDR_WIDTH, 10, log2 of RAM depth in 32-bit words (1024 words = 4 KiB).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- RegWriteM  in  1  register-file write enable from M stage.
- ResultSrcM  in  2  writeback mux select from M stage.
- MemWriteM  in  1  store request.
- MemReadM  in  1  load request.
- ALUResultM  in  DATA_WIDTH  effective byte address, or ALU result.
- WriteDataM  in  DATA_WIDTH  store data, taken from rs2.
- RdM  in  5  destination register.
- PCPlus4M  in  DATA_WIDTH  PC+4.
- LS_modeM  in  3  funct3 access mode: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- RegWriteW  out  1  registered RegWriteM.
- ResultSrcW  out  2  registered ResultSrcM.
- ALUResultW  out  DATA_WIDTH  registered ALUResultM.
- ReadDataW  out  DATA_WIDTH  registered, extended load data.
- RdW  out  5  registered RdM.
- PCPlus4W  out  DATA_WIDTH  registered PCPlus4M.
- MisalignW  out  1  registered misaligned-access flag.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset: on a rising edge with rst=1, all W outputs are driven to 0, including RegWriteW=0 and MisalignW=0. Any store presented in that cycle is suppressed. RAM contents are not cleared.
- Address mapping:
  - Word index = ALUResultM[ADDR_WIDTH+1:2]; byte offset off = ALUResultM[1:0].
  - Upper address bits are ignored, so accesses alias modulo 4 KiB.
- Misalignment: mis = (MemReadM|MemWriteM) & ((H/HU & off[0]) | (W & off!=0)). Byte accesses are never misaligned.
- Store:
  - Condition: MemWriteM=1, mis=0, rst=0. The write happens on the rising edge of the cycle the store is in M.
  - SB writes byte lane off with WriteDataM[7:0].
  - SH writes lanes {off+1, off} with WriteDataM[15:0].
  - SW writes all 4 lanes.
  - Unaddressed lanes are preserved.
  - A misaligned store writes nothing.
  - An undefined LS_mode with MemWriteM=1 writes nothing and sets mis.
- Load:
  - RAM read is asynchronous on the current word index.
  - The selected byte/half is taken at lane off. B/H sign-extend; BU/HU zero-extend; W passes through.
  - The result is registered into ReadDataW. Total latency is 1 cycle, M to W.
  - A misaligned or undefined-mode load yields ReadDataW=0.
  - When MemReadM=0, ReadDataW is don't-care, but must be deterministic; drive 0.
- Read-after-write: a load in the cycle immediately after a store to the same word observes the new data. The write completes at the edge before the read.
- Exception handling: MisalignW is a flag only. RegWriteW is still forwarded unchanged; trap handling is downstream.
- Pipeline register: all W outputs update every rising edge; there is no stall or flush input.
- Simultaneous MemReadM & MemWriteM is illegal from decode. If it occurs, the store is performed and the load returns the pre-write word.

Test Plan:
- Reset: rst=1 with MemWriteM=1, addr 0x0, data 0xFFFFFFFF; then LW 0x0 after previously storing 0x12345678 -> RAM still reads 0x12345678; all W outputs 0 during reset.
- SW 0x100 data 0xDEADBEEF, then next cycle LW 0x100 -> ReadDataW=0xDEADBEEF one cycle after the load; MisalignW=0.
- SB 0x101 data 0x000000AA over 0x11223344, then LW 0x100 -> 0x1122AA44. Then LB 0x101 -> 0xFFFFFFAA; LBU 0x101 -> 0x000000AA.
- SH 0x202 data 0x00008001, then LH 0x202 -> 0xFFFF8001; LHU 0x202 -> 0x00008001; LW 0x200 -> upper half 0x8001, lower half unchanged.
- Misalignment: SW 0x301 -> no write, MisalignW=1; LH 0x303 -> ReadDataW=0, MisalignW=1; LW 0x300 after SW 0x300 data 0x55 -> 0x55, flag 0.
- Passthrough and aliasing: RegWriteM=1, RdM=7, ResultSrcM=2, PCPlus4M=0x44 -> the same values appear on W outputs next cycle. SW 0x1004 data 0x77, then LW 0x0004 -> 0x77 (alias).
